// File: rtl/clk_ce_gen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// Provides the lock-qualification FSM state type and a helper that sizes the lock counter.
package clk_ce_gen_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    WAIT    = 2'd1,
    STRETCH = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam int LOCK_SYNC_STAGES = 2;

  function automatic int lock_cnt_w(input int dly);
    return (dly > 2) ? $clog2(dly) : 1;
  endfunction

endpackage

// File: rtl/clk_ce_gen_if.sv
// Channel configuration and enable outputs of clk_ce_gen.
// The master side drives the configuration; the slave side is the generator.
interface clk_ce_gen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24
);
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*ACC_W-1:0] ch_inc;
  logic [NUM_CH-1:0]       ce_out;
  logic [NUM_CH-1:0]       div_out;
  logic                    rst_out;
  logic                    ready;

  modport master (
    output ch_en, ch_inc,
    input  ce_out, div_out, rst_out, ready
  );

  modport slave (
    input  ch_en, ch_inc,
    output ce_out, div_out, rst_out, ready
  );
endinterface

// File: rtl/clk_ce_nco.sv
// One enable channel: phase accumulator whose carry becomes a registered one-cycle
// enable pulse and toggles a divided square wave.
module clk_ce_nco
  import clk_ce_gen_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             ce,
  output logic             div
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Outside RUN the phase is forced to zero so a relock restarts the cadence cleanly.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      acc <= '0;
      ce  <= 1'b0;
      div <= 1'b0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
      ce  <= sum[ACC_W];
      div <= div ^ sum[ACC_W];
    end else begin
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_ce_gen.sv
// Multi-channel fractional clock-enable generator gated by a debounced PLL lock.
// Owns the lock synchroniser, the lock-qualification FSM and the downstream reset.
//
//   state   | meaning
//   HOLD    | one cycle after reset, lock ignored
//   WAIT    | waiting for synchronised lock, counter reloaded
//   STRETCH | lock seen, counting LOCK_DLY consecutive locked cycles
//   RUN     | lock qualified, channels running, rst_out released
module clk_ce_gen
  import clk_ce_gen_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ACC_W    = 24,
  parameter int LOCK_DLY = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pll_lock,
  clk_ce_gen_if.slave   bus
);

  localparam int             CNT_W    = lock_cnt_w(LOCK_DLY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_DLY - 1);

  logic [LOCK_SYNC_STAGES-1:0] sync_q;
  logic                        lock_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_q, rst_d;
  logic             ready_q, ready_d;
  logic             ch_run;

  logic [NUM_CH-1:0] ce_w;
  logic [NUM_CH-1:0] div_w;

  assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_lock};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= CNT_LOAD;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Lock timer is a down-counter; reaching zero with lock still held qualifies the lock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HOLD: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        cnt_d = CNT_LOAD;
        if (lock_s) state_d = STRETCH;
      end
      STRETCH: begin
        if (!lock_s) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = CNT_LOAD;
        if (!lock_s) state_d = WAIT;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = CNT_LOAD;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    rst_d   = (state_d != RUN);
    ready_d = (state_d == RUN);
    ch_run  = (state_q == RUN) && (state_d == RUN);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_ce_nco #(
      .ACC_W (ACC_W)
    ) u_nco (
      .clk   (clk),
      .reset (reset),
      .run   (ch_run),
      .en    (bus.ch_en[g]),
      .inc   (bus.ch_inc[g*ACC_W +: ACC_W]),
      .ce    (ce_w[g]),
      .div   (div_w[g])
    );
  end

  assign bus.ce_out  = ce_w;
  assign bus.div_out = div_w;
  assign bus.rst_out = rst_q;
  assign bus.ready   = ready_q;

endmodule

// File: tb/tb_clk_ce_gen.sv
// Self-checking bench for clk_ce_gen: table of pulse-count vectors, hand sequences for
// lock corner cases, and randomized stimulus against a lock-streak / arithmetic model.
module tb_clk_ce_gen;
  import clk_ce_gen_pkg::*;

  localparam int     NUM_CH   = 2;
  localparam int     ACC_W    = 8;
  localparam int     LOCK_DLY = 4;
  localparam longint MODV     = longint'(1) << ACC_W;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic pll_lock = 1'b0;

  clk_ce_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

  clk_ce_gen #(
    .NUM_CH   (NUM_CH),
    .ACC_W    (ACC_W),
    .LOCK_DLY (LOCK_DLY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pll_lock (pll_lock),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: lock qualified after LOCK_DLY+1 consecutive synced-lock samples.
  bit     m_ls1, m_ls2, m_hold, m_run;
  int     m_streak;
  longint m_acc [NUM_CH];
  bit     m_ce  [NUM_CH];
  bit     m_div [NUM_CH];

  typedef struct {
    logic [1:0] en;
    logic [7:0] inc0;
    logic [7:0] inc1;
    int         ncyc;
    int         exp0;
    int         exp1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit     seen, was_run;
    longint s;
    if (reset) begin
      m_ls1 = 0; m_ls2 = 0; m_hold = 1; m_run = 0; m_streak = 0;
      for (int n = 0; n < NUM_CH; n++) begin
        m_acc[n] = 0; m_ce[n] = 0; m_div[n] = 0;
      end
    end else begin
      seen    = m_ls2;
      was_run = m_run;
      m_ls2   = m_ls1;
      m_ls1   = pll_lock;
      if (m_hold) begin
        m_hold = 0;
      end else if (m_run) begin
        if (!seen) begin
          m_run = 0;
          m_streak = 0;
        end
      end else begin
        m_streak = seen ? m_streak + 1 : 0;
        if (m_streak >= LOCK_DLY + 1) m_run = 1;
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (was_run && m_run) begin
          if (bus.ch_en[n]) begin
            s        = m_acc[n] + longint'(bus.ch_inc[n*ACC_W +: ACC_W]);
            m_ce[n]  = (s >= MODV);
            m_acc[n] = s % MODV;
            m_div[n] = m_div[n] ^ m_ce[n];
          end else begin
            m_ce[n] = 0;
          end
        end else begin
          m_acc[n] = 0; m_ce[n] = 0; m_div[n] = 0;
        end
      end
    end
  endfunction

  task automatic tick();
    logic [5:0] exp_v, act_v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_v = {~m_run, m_run, m_ce[1], m_ce[0], m_div[1], m_div[0]};
    act_v = {bus.rst_out, bus.ready, bus.ce_out, bus.div_out};
    check("model_outputs", int'(act_v), int'(exp_v));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic bring_up(output int n);
    reset    = 1'b1;
    pll_lock = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n);
  endtask

  initial begin
    int n, c0, c1;

    vecs[0] = '{2'b11, 8'h40, 8'h00,  16,   4,   0};
    vecs[1] = '{2'b11, 8'hFF, 8'h01, 256, 255,   1};
    vecs[2] = '{2'b11, 8'h80, 8'h55,  12,   6,   3};
    vecs[3] = '{2'b01, 8'h40, 8'hC0,  20,   5,   0};
    vecs[4] = '{2'b10, 8'h00, 8'h33,  30,   0,   5};
    vecs[5] = '{2'b11, 8'h01, 8'h80, 255,   0, 127};

    bus.ch_en  = 2'b11;
    bus.ch_inc = {8'h80, 8'h40};

    // Reset state
    reset    = 1'b1;
    pll_lock = 1'b1;
    tick();
    check("reset_state", int'({bus.rst_out, bus.ready, bus.ce_out, bus.div_out}), 'b100000);

    // Lock qualification latency from reset, then exact ch0 cadence at inc 0x40
    bring_up(n);
    check("lock_to_run", n, LOCK_SYNC_STAGES + 1 + LOCK_DLY);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("ce0_cadence", int'(bus.ce_out[0]), (k % 4 == 0) ? 1 : 0);
      check("div0_cadence", int'(bus.div_out[0]), (k / 4) % 2);
    end

    // Pulse counts from phase zero
    foreach (vecs[i]) begin
      bus.ch_en  = vecs[i].en;
      bus.ch_inc = {vecs[i].inc1, vecs[i].inc0};
      bring_up(n);
      check("vec_lock_to_run", n, LOCK_SYNC_STAGES + 1 + LOCK_DLY);
      c0 = 0;
      c1 = 0;
      for (int k = 0; k < vecs[i].ncyc; k++) begin
        tick();
        c0 += int'(bus.ce_out[0]);
        c1 += int'(bus.ce_out[1]);
      end
      check("vec_ce0_count", c0, vecs[i].exp0);
      check("vec_ce1_count", c1, vecs[i].exp1);
    end

    // One-cycle lock glitch during STRETCH restarts qualification
    bus.ch_en  = 2'b11;
    bus.ch_inc = {8'h80, 8'h40};
    reset    = 1'b1;
    pll_lock = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_ready(n);
    check("glitch_relock", n, LOCK_SYNC_STAGES + LOCK_DLY + 1);

    // Lock loss in RUN, then relock restarts phase; ch0 disabled mid-phase
    bus.ch_inc = {8'hFF, 8'h40};
    for (int k = 0; k < 9; k++) tick();
    pll_lock = 1'b0;
    tick();
    check("loss_ready_t1", int'(bus.ready), 1);
    tick();
    check("loss_ready_t2", int'(bus.ready), 1);
    tick();
    check("loss_cleared", int'({bus.rst_out, bus.ready, bus.ce_out, bus.div_out}), 'b100000);
    pll_lock   = 1'b1;
    bus.ch_inc = {8'h80, 8'h40};
    wait_ready(n);
    check("loss_relock", n, LOCK_SYNC_STAGES + LOCK_DLY + 1);
    for (int k = 1; k <= 11; k++) begin
      bus.ch_en = (k >= 7 && k <= 9) ? 2'b10 : 2'b11;
      tick();
      check("en_gap_ce0", int'(bus.ce_out[0]), (k == 4 || k == 11) ? 1 : 0);
      check("en_gap_ce1", int'(bus.ce_out[1]), (k % 2 == 0) ? 1 : 0);
    end

    // Randomized stimulus against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          case ($urandom_range(0, 5))
            0:       bus.ch_inc[ch*ACC_W +: ACC_W] = 8'h00;
            1:       bus.ch_inc[ch*ACC_W +: ACC_W] = 8'hFF;
            2:       bus.ch_inc[ch*ACC_W +: ACC_W] = 8'h01;
            default: bus.ch_inc[ch*ACC_W +: ACC_W] = 8'($urandom);
          endcase
        end
      end
      if ($urandom_range(0, 9) == 0) bus.ch_en = 2'($urandom);
      pll_lock = ($urandom_range(0, 99) >= 3);
      reset    = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
